sim_ctrl_monitor: RTL and testbench

//  Parametrised simulation controller/monitor instantiated beside DATAPATH in the testbench top.

---
 rtl/sim_ctrl_pkg.sv | 20 ++
 rtl/sat_counter.sv | 25 ++
 rtl/sim_ctrl_monitor.sv | 213 +++++++++++++++++++++
 tb/tb_sim_ctrl_monitor.sv | 195 +++++++++++++++++++
 4 files changed

// File: rtl/sim_ctrl_pkg.sv
// Shared types for the simulation controller/monitor: end-of-test status,
// controller state and the default tohost address that test classes also use.
package sim_ctrl_pkg;

    typedef enum logic [1:0] {
        RUNNING = 2'd0,
        PASS    = 2'd1,
        FAIL    = 2'd2,
        HANG    = 2'd3
    } status_t;

    typedef enum logic [1:0] {
        RST_HOLD = 2'd0,
        RUN      = 2'd1,
        DONE     = 2'd2
    } state_t;

    localparam logic [31:0] TOHOST_ADDR_DEFAULT = 32'h0000_1000;

endpackage

// File: rtl/sat_counter.sv
// Saturating up-counter with synchronous clear. The value sticks at all-ones
// instead of wrapping so long runs never report a misleadingly small count.
module sat_counter #(
    parameter int unsigned W = 8
) (
    input  logic         clk,
    input  logic         clr,
    input  logic         inc,
    output logic [W-1:0] q
);

    logic [W-1:0] q_r;

    // Clear has priority; increment stops once the counter is all-ones.
    always_ff @(posedge clk) begin
        if (clr) begin
            q_r <= {W{1'b0}};
        end else if (inc && (q_r != {W{1'b1}})) begin
            q_r <= q_r + {{(W-1){1'b0}}, 1'b1};
        end
    end

    assign q = q_r;

endmodule

// File: rtl/sim_ctrl_monitor.sv
// Simulation controller/monitor placed next to the datapath in the bench top.
// Holds the core in reset for RST_CYCLES edges, then watches PC and the
// data-memory write bus and declares end-of-test on a tohost write, a PC
// self-loop or the watchdog. All outputs are registered and freeze in DONE.
module sim_ctrl_monitor
    import sim_ctrl_pkg::*;
#(
    parameter int unsigned       XLEN         = 32,
    parameter int unsigned       CNT_W        = 32,
    parameter int unsigned       RST_CYCLES   = 4,
    parameter logic [XLEN-1:0]   TOHOST_ADDR  = XLEN'(TOHOST_ADDR_DEFAULT),
    parameter int unsigned       STALL_CYCLES = 8,
    parameter int unsigned       TIMEOUT      = 100000
) (
    input  logic             i_clk,
    input  logic             i_rst,
    input  logic [XLEN-1:0]  i_pc,
    input  logic [XLEN-1:0]  i_dm_addr,
    input  logic [XLEN-1:0]  i_dm_wdata,
    input  logic             i_dm_wen,
    output logic             o_core_rstn,
    output logic             o_done,
    output logic [1:0]       o_status,
    output logic             o_timeout,
    output logic [XLEN-1:0]  o_fail_code,
    output logic [CNT_W-1:0] o_cycles,
    output logic [CNT_W-1:0] o_retired
);

    // Terminal counts are "value before increment" so the event edge is the
    // one on which the counter would reach the programmed limit.
    localparam logic [CNT_W-1:0] HOLD_LAST  = CNT_W'(RST_CYCLES - 32'd1);
    localparam logic [CNT_W-1:0] STALL_LAST = CNT_W'(STALL_CYCLES - 32'd1);
    localparam logic [CNT_W-1:0] WDOG_LAST  = CNT_W'(TIMEOUT - 32'd1);
    localparam logic             STALL_EN   = (STALL_CYCLES != 32'd0);
    localparam logic             WDOG_EN    = (TIMEOUT != 32'd0);

    state_t            state_r;
    state_t            state_nxt_s;
    status_t           status_r;
    status_t           status_nxt_s;
    logic              done_r;
    logic              done_nxt_s;
    logic              timeout_r;
    logic              timeout_nxt_s;
    logic              core_rstn_r;
    logic              core_rstn_nxt_s;
    logic [XLEN-1:0]   fail_code_r;
    logic [XLEN-1:0]   fail_code_nxt_s;
    logic [XLEN-1:0]   prev_pc_r;
    logic              prev_valid_r;

    logic              run_s;
    logic              pc_changed_s;
    logic              retire_s;
    logic              same_pc_s;
    logic              tohost_hit_s;
    logic              tohost_pass_s;
    logic              stall_hit_s;
    logic              wdog_hit_s;
    logic              hold_done_s;
    logic              stall_clr_s;

    logic [CNT_W-1:0]  cycles_q_s;
    logic [CNT_W-1:0]  retired_q_s;
    logic [CNT_W-1:0]  stall_q_s;
    logic [CNT_W-1:0]  wdog_q_s;
    logic [CNT_W-1:0]  hold_q_s;

    // The first RUN cycle has no valid PC history, so it neither retires nor stalls.
    assign run_s         = (state_r == RUN);
    assign pc_changed_s  = (i_pc != prev_pc_r);
    assign retire_s      = run_s && prev_valid_r && pc_changed_s;
    assign same_pc_s     = run_s && prev_valid_r && !pc_changed_s;
    assign stall_clr_s   = i_rst || retire_s;

    // A zero tohost value is not a verdict and is ignored.
    assign tohost_hit_s  = run_s && i_dm_wen && (i_dm_addr == TOHOST_ADDR)
                           && (i_dm_wdata != {XLEN{1'b0}});
    assign tohost_pass_s = (i_dm_wdata == {{(XLEN-1){1'b0}}, 1'b1});
    assign stall_hit_s   = STALL_EN && same_pc_s && (stall_q_s == STALL_LAST);
    assign wdog_hit_s    = WDOG_EN && run_s && (wdog_q_s == WDOG_LAST);
    assign hold_done_s   = (hold_q_s == HOLD_LAST);

    sat_counter #(.W(CNT_W)) u_cycle_cnt (
        .clk (i_clk),
        .clr (i_rst),
        .inc (run_s),
        .q   (cycles_q_s)
    );

    sat_counter #(.W(CNT_W)) u_retire_cnt (
        .clk (i_clk),
        .clr (i_rst),
        .inc (retire_s),
        .q   (retired_q_s)
    );

    sat_counter #(.W(CNT_W)) u_stall_cnt (
        .clk (i_clk),
        .clr (stall_clr_s),
        .inc (same_pc_s),
        .q   (stall_q_s)
    );

    sat_counter #(.W(CNT_W)) u_wdog_cnt (
        .clk (i_clk),
        .clr (i_rst),
        .inc (run_s),
        .q   (wdog_q_s)
    );

    sat_counter #(.W(CNT_W)) u_hold_cnt (
        .clk (i_clk),
        .clr (i_rst),
        .inc (state_r == RST_HOLD),
        .q   (hold_q_s)
    );

    // PC history: sampled every RUN cycle, invalid outside RUN so RUN entry starts clean.
    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            prev_pc_r    <= {XLEN{1'b0}};
            prev_valid_r <= 1'b0;
        end else if (run_s) begin
            prev_pc_r    <= i_pc;
            prev_valid_r <= 1'b1;
        end else if (state_r == RST_HOLD) begin
            prev_valid_r <= 1'b0;
        end
    end

    // Next state and next output values; end conditions ranked tohost > stall > watchdog.
    always_comb begin
        state_nxt_s     = state_r;
        status_nxt_s    = status_r;
        done_nxt_s      = done_r;
        timeout_nxt_s   = timeout_r;
        fail_code_nxt_s = fail_code_r;
        core_rstn_nxt_s = core_rstn_r;
        case (state_r)
            RST_HOLD: begin
                if (hold_done_s) begin
                    state_nxt_s     = RUN;
                    core_rstn_nxt_s = 1'b1;
                end else begin
                    state_nxt_s     = RST_HOLD;
                    core_rstn_nxt_s = 1'b0;
                end
            end
            RUN: begin
                if (tohost_hit_s) begin
                    state_nxt_s = DONE;
                    done_nxt_s  = 1'b1;
                    if (tohost_pass_s) begin
                        status_nxt_s    = PASS;
                        fail_code_nxt_s = {XLEN{1'b0}};
                    end else begin
                        status_nxt_s    = FAIL;
                        fail_code_nxt_s = {1'b0, i_dm_wdata[XLEN-1:1]};
                    end
                end else if (stall_hit_s) begin
                    state_nxt_s   = DONE;
                    done_nxt_s    = 1'b1;
                    status_nxt_s  = HANG;
                    timeout_nxt_s = 1'b0;
                end else if (wdog_hit_s) begin
                    state_nxt_s   = DONE;
                    done_nxt_s    = 1'b1;
                    status_nxt_s  = HANG;
                    timeout_nxt_s = 1'b1;
                end else begin
                    state_nxt_s = RUN;
                end
            end
            DONE: begin
                state_nxt_s = DONE;
            end
            default: begin
                state_nxt_s     = RST_HOLD;
                core_rstn_nxt_s = 1'b0;
            end
        endcase
    end

    // State and status registers; reset returns everything to RST_HOLD from any state.
    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            state_r     <= RST_HOLD;
            status_r    <= RUNNING;
            done_r      <= 1'b0;
            timeout_r   <= 1'b0;
            fail_code_r <= {XLEN{1'b0}};
            core_rstn_r <= 1'b0;
        end else begin
            state_r     <= state_nxt_s;
            status_r    <= status_nxt_s;
            done_r      <= done_nxt_s;
            timeout_r   <= timeout_nxt_s;
            fail_code_r <= fail_code_nxt_s;
            core_rstn_r <= core_rstn_nxt_s;
        end
    end

    assign o_core_rstn = core_rstn_r;
    assign o_done      = done_r;
    assign o_status    = status_r;
    assign o_timeout   = timeout_r;
    assign o_fail_code = fail_code_r;
    assign o_cycles    = cycles_q_s;
    assign o_retired   = retired_q_s;

endmodule

// File: tb/tb_sim_ctrl_monitor.sv
// Directed bench for sim_ctrl_monitor: reset sequencing, PASS/FAIL verdicts,
// PC-stall hang, watchdog timeout, priority and mid-run reset.
module tb_sim_ctrl_monitor;

    logic        i_clk;
    logic        i_rst;
    logic [31:0] i_pc;
    logic [31:0] i_dm_addr;
    logic [31:0] i_dm_wdata;
    logic        i_dm_wen;
    logic        o_core_rstn;
    logic        o_done;
    logic [1:0]  o_status;
    logic        o_timeout;
    logic [31:0] o_fail_code;
    logic [31:0] o_cycles;
    logic [31:0] o_retired;

    int n_checks;
    int n_errors;

    sim_ctrl_monitor #(
        .XLEN         (32),
        .CNT_W        (32),
        .RST_CYCLES   (4),
        .TOHOST_ADDR  (32'h0000_1000),
        .STALL_CYCLES (8),
        .TIMEOUT      (50)
    ) dut (
        .i_clk       (i_clk),
        .i_rst       (i_rst),
        .i_pc        (i_pc),
        .i_dm_addr   (i_dm_addr),
        .i_dm_wdata  (i_dm_wdata),
        .i_dm_wen    (i_dm_wen),
        .o_core_rstn (o_core_rstn),
        .o_done      (o_done),
        .o_status    (o_status),
        .o_timeout   (o_timeout),
        .o_fail_code (o_fail_code),
        .o_cycles    (o_cycles),
        .o_retired   (o_retired)
    );

    initial i_clk = 1'b0;
    always #5 i_clk = ~i_clk;

    task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge i_clk);
        #1;
    endtask

    task automatic run_cycle(input logic [31:0] pc, input logic wen,
                             input logic [31:0] addr, input logic [31:0] wdata);
        i_pc       = pc;
        i_dm_wen   = wen;
        i_dm_addr  = addr;
        i_dm_wdata = wdata;
        tick();
    endtask

    // One-cycle reset pulse, check reset values, then the 4-edge hold sequence.
    task automatic do_reset(input logic poke_tohost);
        i_rst    = 1'b1;
        i_dm_wen = 1'b0;
        tick();
        check_eq("rst_rstn",    32'(o_core_rstn), 32'd0);
        check_eq("rst_done",    32'(o_done),      32'd0);
        check_eq("rst_status",  32'(o_status),    32'd0);
        check_eq("rst_timeout", 32'(o_timeout),   32'd0);
        check_eq("rst_fcode",   o_fail_code,      32'd0);
        check_eq("rst_cycles",  o_cycles,         32'd0);
        check_eq("rst_retired", o_retired,        32'd0);
        i_rst      = 1'b0;
        i_dm_wen   = poke_tohost;
        i_dm_addr  = 32'h0000_1000;
        i_dm_wdata = 32'd1;
        for (int k = 1; k <= 3; k++) begin
            i_pc = 32'h0000_0300 + 32'(k);
            tick();
            check_eq("hold_rstn", 32'(o_core_rstn), 32'd0);
        end
        tick();
        check_eq("hold_end_rstn",   32'(o_core_rstn), 32'd1);
        check_eq("hold_end_status", 32'(o_status),    32'd0);
        check_eq("hold_end_done",   32'(o_done),      32'd0);
        check_eq("hold_end_cycles", o_cycles,         32'd0);
        i_dm_wen = 1'b0;
    endtask

    initial begin
        n_checks   = 0;
        n_errors   = 0;
        i_rst      = 1'b1;
        i_pc       = 32'd0;
        i_dm_addr  = 32'd0;
        i_dm_wdata = 32'd0;
        i_dm_wen   = 1'b0;

        // Tests 1 and 2: reset sequencing, then PASS at RUN cycle 20.
        do_reset(1'b0);
        for (int n = 1; n <= 20; n++) begin
            run_cycle(32'h0000_0100 + 32'(4 * n), (n == 20), 32'h0000_1000, 32'd1);
            if (n == 19) check_eq("pass_pre_done", 32'(o_done), 32'd0);
        end
        check_eq("pass_status",  32'(o_status), 32'd1);
        check_eq("pass_done",    32'(o_done),   32'd1);
        check_eq("pass_cycles",  o_cycles,      32'd20);
        check_eq("pass_retired", o_retired,     32'd19);
        check_eq("pass_fcode",   o_fail_code,   32'd0);
        for (int n = 21; n <= 23; n++) begin
            run_cycle(32'h0000_0100 + 32'(4 * n), 1'b0, 32'd0, 32'd0);
        end
        check_eq("pass_frozen_cycles", o_cycles,         32'd20);
        check_eq("pass_frozen_rstn",   32'(o_core_rstn), 32'd1);

        // Test 3: tohost write during hold ignored, zero write ignored, then FAIL code 5.
        do_reset(1'b1);
        for (int n = 1; n <= 5; n++) begin
            run_cycle(32'h0000_0100 + 32'(4 * n), (n == 3) || (n == 5), 32'h0000_1000,
                      (n == 3) ? 32'd0 : 32'h0000_000B);
            if (n == 3) check_eq("zero_write_status", 32'(o_status), 32'd0);
        end
        check_eq("fail_status",  32'(o_status), 32'd2);
        check_eq("fail_fcode",   o_fail_code,   32'd5);
        check_eq("fail_done",    32'(o_done),   32'd1);
        check_eq("fail_cycles",  o_cycles,      32'd5);
        check_eq("fail_retired", o_retired,     32'd4);
        run_cycle(32'h0000_0500, 1'b1, 32'h0000_1000, 32'd1);
        check_eq("fail_sticky_status", 32'(o_status), 32'd2);
        check_eq("fail_sticky_fcode",  o_fail_code,   32'd5);

        // Test 4a: PC parked at 0x40 from cycle 10 -> hang after 8 unchanged cycles.
        do_reset(1'b0);
        for (int n = 1; n <= 18; n++) begin
            run_cycle((n < 10) ? 32'h0000_0100 + 32'(4 * n) : 32'h0000_0040,
                      1'b0, 32'd0, 32'd0);
            if (n == 17) check_eq("stall_pre_status", 32'(o_status), 32'd0);
        end
        check_eq("stall_status",  32'(o_status),  32'd3);
        check_eq("stall_timeout", 32'(o_timeout), 32'd0);
        check_eq("stall_cycles",  o_cycles,       32'd18);
        check_eq("stall_retired", o_retired,      32'd9);

        // Test 4b: same stall, but tohost PASS on the stall-hit cycle wins.
        do_reset(1'b0);
        for (int n = 1; n <= 18; n++) begin
            run_cycle((n < 10) ? 32'h0000_0100 + 32'(4 * n) : 32'h0000_0040,
                      (n == 18), 32'h0000_1000, 32'd1);
        end
        check_eq("prio_status",  32'(o_status),  32'd1);
        check_eq("prio_timeout", 32'(o_timeout), 32'd0);

        // Test 5: watchdog with TIMEOUT=50, PC always moving.
        do_reset(1'b0);
        for (int n = 1; n <= 50; n++) begin
            run_cycle(32'h0000_0100 + 32'(4 * n), 1'b0, 32'd0, 32'd0);
            if (n == 49) check_eq("wdog_pre_status", 32'(o_status), 32'd0);
        end
        check_eq("wdog_status",  32'(o_status),  32'd3);
        check_eq("wdog_timeout", 32'(o_timeout), 32'd1);
        check_eq("wdog_cycles",  o_cycles,       32'd50);
        check_eq("wdog_retired", o_retired,      32'd49);
        for (int n = 51; n <= 53; n++) begin
            run_cycle(32'h0000_0100 + 32'(4 * n), 1'b0, 32'd0, 32'd0);
        end
        check_eq("wdog_frozen_cycles", o_cycles, 32'd50);

        // Test 6: reset mid-RUN at cycle 30, hold repeats, then a clean PASS.
        do_reset(1'b0);
        for (int n = 1; n <= 30; n++) begin
            run_cycle(32'h0000_0100 + 32'(4 * n), 1'b0, 32'd0, 32'd0);
        end
        check_eq("midrun_cycles", o_cycles, 32'd30);
        do_reset(1'b0);
        for (int n = 1; n <= 5; n++) begin
            run_cycle(32'h0000_0800 + 32'(4 * n), (n == 5), 32'h0000_1000, 32'd1);
        end
        check_eq("rerun_status",  32'(o_status), 32'd1);
        check_eq("rerun_cycles",  o_cycles,      32'd5);
        check_eq("rerun_retired", o_retired,     32'd4);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
